// File: rtl/operand_sel_pipe.sv
// Operand-B select stage: resolves rd2 (with EX/WB forwarding), extended immediate or an extra
// source at input acceptance, then holds the result in a 2-entry FIFO toward the consumer.
module operand_sel_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned NUM_EXTRA = 2,
  localparam int unsigned NUM_SRC  = NUM_EXTRA + 2,
  localparam int unsigned SEL_W    = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned EXTRA_W  = (NUM_EXTRA > 0) ? NUM_EXTRA * DATA_W : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DATA_W-1:0]  in_rd2,
  input  logic [4:0]         in_rs2,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_ext_mode,
  input  logic [EXTRA_W-1:0] in_extra,
  input  logic               fwd_ex_en,
  input  logic [4:0]         fwd_ex_reg,
  input  logic [DATA_W-1:0]  fwd_ex_data,
  input  logic               fwd_wb_en,
  input  logic [4:0]         fwd_wb_reg,
  input  logic [DATA_W-1:0]  fwd_wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_operand,
  output logic               out_err,
  output logic               out_fwd
);

  localparam int unsigned ENTRY_W = DATA_W + 2;

  // Entry layout: {operand, err, fwd}
  logic [ENTRY_W-1:0] mem_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] head;

  logic               push, pop;
  logic [DATA_W-1:0]  imm_ext;
  logic               ex_hit, wb_hit;
  int unsigned        sel_idx;
  logic [DATA_W-1:0]  res_operand;
  logic               res_err, res_fwd;

  assign sel_idx = 32'(in_sel);
  assign imm_ext = {{(DATA_W - IMM_W){in_ext_mode & in_imm[IMM_W-1]}}, in_imm};
  // Register x0 is hardwired to zero, so it is never forwarded.
  assign ex_hit  = fwd_ex_en && (fwd_ex_reg == in_rs2) && (in_rs2 != 5'd0);
  assign wb_hit  = fwd_wb_en && (fwd_wb_reg == in_rs2) && (in_rs2 != 5'd0);

  always_comb begin
    res_operand = '0;
    res_err     = 1'b0;
    res_fwd     = 1'b0;
    if (sel_idx == 0) begin
      if (ex_hit) begin
        res_operand = fwd_ex_data;
        res_fwd     = 1'b1;
      end else if (wb_hit) begin
        res_operand = fwd_wb_data;
        res_fwd     = 1'b1;
      end else begin
        res_operand = in_rd2;
      end
    end else if (sel_idx == 1) begin
      res_operand = imm_ext;
    end else if (sel_idx < NUM_SRC) begin
      for (int unsigned k = 0; k < NUM_EXTRA; k++) begin
        if (sel_idx == k + 2) res_operand = in_extra[k*DATA_W +: DATA_W];
      end
    end else begin
      res_err = 1'b1;
    end
  end

  assign in_ready = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {res_operand, res_err, res_fwd};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Outputs read zero whenever the buffer is empty so stale entries never leak out.
  assign head        = mem_q[rd_ptr_q];
  assign out_operand = out_valid ? head[ENTRY_W-1:2] : '0;
  assign out_err     = out_valid & head[1];
  assign out_fwd     = out_valid & head[0];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe (NUM_EXTRA=1) with a queue scoreboard checked on negedge.
module tb_operand_sel_pipe;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_rd2;
  logic [4:0]  in_rs2;
  logic [15:0] in_imm;
  logic        in_ext_mode;
  logic [31:0] in_extra;
  logic        fwd_ex_en, fwd_wb_en;
  logic [4:0]  fwd_ex_reg, fwd_wb_reg;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_operand;
  logic        out_err, out_fwd;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [31:0] exp_op;
  logic        exp_err, exp_fwd;
  logic [33:0] sb_q[$];

  operand_sel_pipe #(
    .DATA_W   (32),
    .IMM_W    (16),
    .NUM_EXTRA(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_rd2     (in_rd2),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_ext_mode(in_ext_mode),
    .in_extra   (in_extra),
    .fwd_ex_en  (fwd_ex_en),
    .fwd_ex_reg (fwd_ex_reg),
    .fwd_ex_data(fwd_ex_data),
    .fwd_wb_en  (fwd_wb_en),
    .fwd_wb_reg (fwd_wb_reg),
    .fwd_wb_data(fwd_wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_operand(out_operand),
    .out_err    (out_err),
    .out_fwd    (out_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Scoreboard: outputs are compared before the edge that transfers them.
  always @(negedge clk) begin
    logic [33:0] head;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      check("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
      if (out_valid && sb_q.size() != 0) begin
        head = sb_q[0];
        check("out_operand", {32'd0, out_operand}, {32'd0, head[33:2]});
        check("out_err", {63'd0, out_err}, {63'd0, head[1]});
        check("out_fwd", {63'd0, out_fwd}, {63'd0, head[0]});
        if (out_ready) begin
          head = sb_q.pop_front();
          delivered++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back({exp_op, exp_err, exp_fwd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] rd2, input logic [4:0] rs2,
                       input logic [15:0] imm, input logic ext, input logic [31:0] extra,
                       input logic [31:0] eop, input logic eerr, input logic efwd);
    in_valid    = 1'b1;
    in_sel      = sel;
    in_rd2      = rd2;
    in_rs2      = rs2;
    in_imm      = imm;
    in_ext_mode = ext;
    in_extra    = extra;
    exp_op      = eop;
    exp_err     = eerr;
    exp_fwd     = efwd;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_operand"}, {32'd0, out_operand}, 64'd0);
    check({tag, "_err"}, {63'd0, out_err}, 64'd0);
    check({tag, "_fwd"}, {63'd0, out_fwd}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sel = '0; in_rd2 = '0; in_rs2 = '0; in_imm = '0; in_ext_mode = 1'b0; in_extra = '0;
    fwd_ex_en = 1'b0; fwd_ex_reg = '0; fwd_ex_data = '0;
    fwd_wb_en = 1'b0; fwd_wb_reg = '0; fwd_wb_data = '0;
    exp_op = '0; exp_err = 1'b0; exp_fwd = 1'b0;

    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    idle(1);

    // Immediate extension
    drive(2'd1, 32'h0, 5'd0, 16'h8000, 1'b1, 32'h0, 32'hFFFF_8000, 1'b0, 1'b0); tick();
    drive(2'd1, 32'h0, 5'd0, 16'h8000, 1'b0, 32'h0, 32'h0000_8000, 1'b0, 1'b0); tick();
    drive(2'd1, 32'h0, 5'd0, 16'h7FFF, 1'b1, 32'h0, 32'h0000_7FFF, 1'b0, 1'b0); tick();
    idle(2);

    // Forwarding priority and x0 exclusion
    fwd_ex_en = 1'b1; fwd_ex_reg = 5'd5; fwd_ex_data = 32'hAA;
    fwd_wb_en = 1'b1; fwd_wb_reg = 5'd5; fwd_wb_data = 32'hBB;
    drive(2'd0, 32'h11, 5'd5, 16'h0, 1'b0, 32'h0, 32'hAA, 1'b0, 1'b1); tick();
    fwd_ex_en = 1'b0;
    drive(2'd0, 32'h11, 5'd5, 16'h0, 1'b0, 32'h0, 32'hBB, 1'b0, 1'b1); tick();
    fwd_ex_en = 1'b1; fwd_ex_reg = 5'd0; fwd_wb_reg = 5'd0;
    drive(2'd0, 32'h11, 5'd0, 16'h0, 1'b0, 32'h0, 32'h11, 1'b0, 1'b0); tick();
    fwd_ex_reg = 5'd6; fwd_wb_reg = 5'd7;
    drive(2'd0, 32'h22, 5'd7, 16'h0, 1'b0, 32'h0, 32'hBB, 1'b0, 1'b1); tick();
    fwd_ex_reg = 5'd7; fwd_wb_reg = 5'd7;
    drive(2'd1, 32'h22, 5'd7, 16'h0012, 1'b0, 32'h0, 32'h12, 1'b0, 1'b0); tick();
    fwd_ex_en = 1'b0; fwd_wb_en = 1'b0;
    idle(2);

    // Extra source and out-of-range select
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0); tick();
    drive(2'd3, 32'h5, 5'd0, 16'hFFFF, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b0); tick();
    idle(2);

    // Backpressure: A, B fill the buffer, C is refused; stored values ignore later input changes
    out_ready = 1'b0;
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'hA, 32'hA, 1'b0, 1'b0); tick();
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'hB, 32'hB, 1'b0, 1'b0); tick();
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'hC, 32'hC, 1'b0, 1'b0);
    tick(); tick(); tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    base = delivered;
    idle(3);
    check("stall_delivered", 64'(delivered - base), 64'd2);
    check("stall_drained", {63'd0, out_valid}, 64'd0);

    // Flush at count 2 with an offered entry
    out_ready = 1'b0;
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0); tick();
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h2, 32'h2, 1'b0, 1'b0); tick();
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h3, 32'h3, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("flush");
    out_ready = 1'b1;
    idle(2);

    // Reset mid-operation, asserted together with flush
    out_ready = 1'b0;
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h4, 32'h4, 1'b0, 1'b0); tick();
    drive(2'd1, 32'h0, 5'd0, 16'hF00F, 1'b1, 32'h0, 32'hFFFF_F00F, 1'b0, 1'b0); tick();
    drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h6, 32'h6, 1'b0, 1'b0);
    rst_n = 1'b0; flush = 1'b1;
    tick();
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(2);
    check("midrst_after", {63'd0, out_valid}, 64'd0);

    // Streaming: 8 back-to-back transfers with no bubbles
    base = delivered;
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 32'h0, 5'd0, 16'h0, 1'b0, 32'h1111_1111 * (i + 1), 32'h1111_1111 * (i + 1),
            1'b0, 1'b0);
      tick();
    end
    idle(3);
    check("stream_delivered", 64'(delivered - base), 64'd8);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter IMM_W, default 16, raw immediate width (IMM_W < DATA_W).
REQ-003 SHALL have parameter NUM_EXTRA, default 2, number of extra generic sources (>= 0).
REQ-004 SHALL derive local NUM_SRC = NUM_EXTRA+2 and SEL_W = max(1, clog2(NUM_SRC)).
REQ-005 SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 flush  in  1  synchronous buffer clear.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-010 in_sel  in  SEL_W  source select: 0=rd2, 1=extended immediate, 2..NUM_SRC-1=extra_src[k-2].
REQ-011 in_rd2 / in_rs2  in  DATA_W / 5  register-file operand and its register number.
REQ-012 in_imm / in_ext_mode  in  IMM_W / 1  raw immediate; extension mode, 0=zero, 1=sign.
REQ-013 in_extra  in  NUM_EXTRA*DATA_W (min 1)  flattened extra sources, index k at bits [k*DATA_W +: DATA_W].
REQ-014 fwd_ex_en, fwd_ex_reg, fwd_ex_data  in  1, 5, DATA_W  EX-stage forward.
REQ-015 fwd_wb_en, fwd_wb_reg, fwd_wb_data  in  1, 5, DATA_W  WB-stage forward.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 out_operand  out  DATA_W  selected operand B.
REQ-018 out_err  out  1  entry was captured with in_sel >= NUM_SRC.
REQ-019 out_fwd  out  1  entry value came from a forward path.

Function
REQ-020 Transfer SHALL occur on the input side when in_valid&in_ready, and on the output side when out_valid&out_ready, both at the rising clk edge.
REQ-021 Operand SHALL be resolved at input acceptance and stored; later changes to inputs or forwards SHALL NOT alter a stored entry.
REQ-022 in_sel=0: if fwd_ex_en and fwd_ex_reg==in_rs2 and in_rs2!=0, take fwd_ex_data; else if the same condition holds for WB, take fwd_wb_data; else in_rd2; EX SHALL have priority over WB.
REQ-023 out_fwd SHALL be 1 only when REQ-022 selected a forward path; 0 for all other in_sel values.
REQ-024 in_sel=1: in_imm zero- or sign-extended to DATA_W per in_ext_mode.
REQ-025 in_sel >= NUM_SRC: operand SHALL be 0 and out_err=1; the entry is still accepted and delivered.
REQ-026 Buffer SHALL be a 2-entry FIFO with count 0..2; in_ready = (count<2) and is independent of in_valid.
REQ-027 out_valid = (count>0); out_operand/out_err/out_fwd SHALL show the oldest entry and hold stable while out_valid&!out_ready.
REQ-028 Latency SHALL be 1 cycle: an entry accepted into an empty buffer SHALL appear with out_valid=1 on the next cycle.
REQ-029 Simultaneous push and pop at count 1 SHALL leave count 1 with the new entry at the head next cycle; at count 2 no push is possible.
REQ-030 Sustained in_valid=out_ready=1 SHALL give one transfer per cycle with no bubbles.
REQ-031 flush SHALL set count to 0 next cycle, SHALL override push and pop in the same cycle, and SHALL discard the input offered in that cycle.

Reset
REQ-032 While rst_n=0 at a clk edge: count=0, out_valid=0, out_operand=0, out_err=0, out_fwd=0; in_ready SHALL read 1 from the first cycle after reset.
REQ-033 Reset mid-operation SHALL discard all stored entries without an output transfer; rst_n SHALL override flush.

Verification
REQ-034 in_sel=1, in_imm=16'h8000, in_ext_mode=1 -> next cycle out_operand=32'hFFFF8000, out_err=0; with in_ext_mode=0 -> 32'h00008000.
REQ-035 in_sel=0, in_rs2=5, in_rd2=32'h11, EX fwd reg 5 data 32'hAA, WB fwd reg 5 data 32'hBB -> 32'hAA, out_fwd=1; EX disabled -> 32'hBB; in_rs2=0 with both enabled -> 32'h11, out_fwd=0.
REQ-036 out_ready=0, push A, B, C -> in_ready=0 after B, C not accepted; raise out_ready -> A then B delivered in order, out_operand held stable while stalled.
REQ-037 in_sel=3 with NUM_EXTRA=1 -> out_operand=0, out_err=1; in_sel=2 -> in_extra[31:0].
REQ-038 Count 2 with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry absent; repeat with rst_n=0 -> same result and all outputs 0.
REQ-039 In_valid=out_ready=1 for 8 cycles with distinct operands -> 8 outputs on consecutive cycles, in order, first one cycle after first accept.
